cs_serial_resolve: RTL and testbench



---
 rtl/vdf_pkg.sv | 13 +
 rtl/chunk_adder.sv | 16 +
 rtl/cs_serial_resolve.sv | 117 +++++++++++
 tb/tb_cs_serial_resolve.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/vdf_pkg.sv
// Shared definitions for the VDF squaring datapath.
// Holds the squarer output width and the resolver FSM state type.
package vdf_pkg;

    localparam int SQ_OUT_BITS = 2112;

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } res_state_t;

endpackage

// File: rtl/chunk_adder.sv
// One CHUNK_BITS-wide slice of the serial carry-propagate adder.
// Purely combinational; the caller registers the carry between slices.
module chunk_adder #(
    parameter int CHUNK_BITS = 132
) (
    input  logic [CHUNK_BITS-1:0] a,
    input  logic [CHUNK_BITS-1:0] b,
    input  logic                  cin,
    output logic [CHUNK_BITS-1:0] r,
    output logic                  cout
);

    assign {cout, r} = {1'b0, a} + {1'b0, b}
                     + {{CHUNK_BITS{1'b0}}, cin};

endmodule

// File: rtl/cs_serial_resolve.sv
// Resolves the squarer's redundant (C, S) pair into a binary square,
// one chunk per cycle, least significant chunk first.
module cs_serial_resolve
    import vdf_pkg::*;
#(
    parameter int TOTAL_BITS = SQ_OUT_BITS,
    parameter int CHUNK_BITS = 132
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [TOTAL_BITS-1:0] C,
    input  logic [TOTAL_BITS-1:0] S,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [TOTAL_BITS-1:0] sum,
    output logic                  carry_out
);

    localparam int NUM_CHUNKS = TOTAL_BITS / CHUNK_BITS;
    localparam int CNT_W      = $clog2(NUM_CHUNKS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_CHUNKS - 1);

    generate
        if (TOTAL_BITS % CHUNK_BITS != 0) begin : g_bad_chunk
            $error("TOTAL_BITS must be a multiple of CHUNK_BITS");
        end
    endgenerate

    res_state_t            r_state;
    res_state_t            w_next;
    logic [TOTAL_BITS-1:0] r_c;
    logic [TOTAL_BITS-1:0] r_s;
    logic [TOTAL_BITS-1:0] r_sum;
    logic                  r_carry;
    logic                  r_cout;
    logic [CNT_W-1:0]      r_cnt;
    logic [CHUNK_BITS-1:0] w_r;
    logic                  w_cout;
    logic                  w_last;

    chunk_adder #(
        .CHUNK_BITS(CHUNK_BITS)
    ) u_chunk_adder (
        .a   (r_c[CHUNK_BITS-1:0]),
        .b   (r_s[CHUNK_BITS-1:0]),
        .cin (r_carry),
        .r   (w_r),
        .cout(w_cout)
    );

    assign w_last    = (r_cnt == LAST_CNT);
    assign sum       = r_sum;
    assign carry_out = r_cout;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next = ADD;
            end
            ADD: begin
                if (w_last) w_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Result chunks enter at the top so the first (lowest) chunk ends at bit 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_c     <= '0;
            r_s     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_c     <= C;
                        r_s     <= S;
                        r_carry <= 1'b0;
                        r_cnt   <= '0;
                    end
                end
                ADD: begin
                    r_c     <= r_c >> CHUNK_BITS;
                    r_s     <= r_s >> CHUNK_BITS;
                    r_sum   <= {w_r, r_sum[TOTAL_BITS-1:CHUNK_BITS]};
                    r_carry <= w_cout;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (w_last) r_cout <= w_cout;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cs_serial_resolve.sv
// Self-checking bench for cs_serial_resolve at the default 2112/132 size.
// Expected results come from a plain unsigned C+S reference.
module tb_cs_serial_resolve;

    localparam int TB = 2112;
    localparam int CB = 132;
    localparam int NC = TB / CB;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready;
    logic          carry_out;
    logic [TB-1:0] C;
    logic [TB-1:0] S;
    logic [TB-1:0] sum;

    int            checks = 0;
    int            errors = 0;
    logic          exp_valid = 1'b0;
    logic [TB:0]   exp_val = '0;
    logic [TB:0]   res;
    logic [TB-1:0] ones;
    logic [TB-1:0] bnd;
    logic [TB:0]   lit;

    always #5 clk = ~clk;

    cs_serial_resolve dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .C        (C),
        .S        (S),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .carry_out(carry_out)
    );

    function automatic logic [TB-1:0] rnd_word();
        logic [TB-1:0] w;
        w = '0;
        for (int i = 0; i < TB / 32; i++) w[i*32 +: 32] = $urandom();
        return w;
    endfunction

    task automatic chk(input string name, input logic [TB:0] act,
                       input logic [TB:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h (low 128 bits)",
                     name, act[127:0], exp[127:0]);
        end
    endtask

    // Reference compare: any visible result must equal the pending C+S.
    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid) begin
                chk("result_pending", {TB'(0), exp_valid}, {TB'(0), 1'b1});
                chk("result_value", {carry_out, sum}, exp_val);
            end
            chk("ready_valid_excl", {TB'(0), in_ready & out_valid}, '0);
        end
    end

    // stall < 0 holds out_ready high from the accept edge onward.
    task automatic do_op(input logic [TB-1:0] c, input logic [TB-1:0] s,
                         input int stall, input bit inject,
                         output logic [TB:0] r);
        int n;
        logic [TB:0] held;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk("in_ready_wait", {TB'(0), in_ready}, {TB'(0), 1'b1});
        C = c; S = s; in_valid = 1'b1;
        out_ready = (stall < 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        C = rnd_word(); S = rnd_word();
        exp_val = {1'b0, c} + {1'b0, s};
        exp_valid = 1'b1;
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk("latency", TB'(n), TB'(NC));
        r = {carry_out, sum};
        held = r;
        for (int k = 0; k < stall; k++) begin
            if (inject) begin
                C = rnd_word(); S = rnd_word(); in_valid = 1'b1;
            end
            @(posedge clk); #1;
            if (inject) begin
                chk("bp_in_ready", {TB'(0), in_ready}, '0);
                chk("bp_stable", {carry_out, sum}, held);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        exp_valid = 1'b0;
        chk("post_e1_ready", {TB'(0), in_ready}, {TB'(0), 1'b1});
        chk("post_e1_valid", {TB'(0), out_valid}, '0);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        C = '0; S = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_in_ready", {TB'(0), in_ready}, {TB'(0), 1'b1});
        chk("rst_out_valid", {TB'(0), out_valid}, '0);
        chk("rst_sum_cout", {carry_out, sum}, '0);

        do_op('0, '0, 0, 1'b0, res);
        chk("zeros_lit", res, '0);

        ones = '1;
        do_op(ones, TB'(1), 2, 1'b0, res);
        lit = '0; lit[TB] = 1'b1;
        chk("ripple_lit", res, lit);

        bnd = '0; bnd[131] = 1'b1;
        do_op(bnd, bnd, -1, 1'b0, res);
        lit = '0; lit[132] = 1'b1;
        chk("boundary_lit", res, lit);

        do_op(rnd_word(), rnd_word(), 10, 1'b1, res);

        // Abandon an operation partway through ADD.
        C = rnd_word(); S = rnd_word(); in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1 reset = 1'b1;
        exp_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("midrst_in_ready", {TB'(0), in_ready}, {TB'(0), 1'b1});
        chk("midrst_out_valid", {TB'(0), out_valid}, '0);
        chk("midrst_sum", {carry_out, sum}, '0);
        do_op(TB'(3), TB'(5), 1, 1'b0, res);
        chk("three_five_lit", res, (TB+1)'(8));

        for (int i = 0; i < 300; i++) begin
            do_op(rnd_word(), rnd_word(),
                  int'($urandom_range(0, 4)) - 1, 1'b0, res);
        end
        ones = '1;
        do_op(ones, ones, 0, 1'b0, res);
        lit = '1; lit[0] = 1'b0;
        chk("max_lit", res, lit);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
